// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;
  localparam logic [4:0] CP0_REG_PRID    = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_TYPE_INT     = 32'h1;
  localparam logic [31:0] EXC_TYPE_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_TYPE_RI      = 32'ha;
  localparam logic [31:0] EXC_TYPE_OV      = 32'hc;
  localparam logic [31:0] EXC_TYPE_TRAP    = 32'hd;
  localparam logic [31:0] EXC_TYPE_ERET    = 32'he;

  localparam logic [4:0] EXC_CODE_INT     = 5'd0;
  localparam logic [4:0] EXC_CODE_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_CODE_RI      = 5'd10;
  localparam logic [4:0] EXC_CODE_OV      = 5'd12;
  localparam logic [4:0] EXC_CODE_TRAP    = 5'd13;

  localparam int STATUS_EXL      = 1;
  localparam int CAUSE_BD        = 31;
  localparam int CAUSE_IV        = 23;
  localparam int CAUSE_WP        = 22;
  localparam int CAUSE_IP_HW_HI  = 15;
  localparam int CAUSE_IP_HW_LO  = 10;
  localparam int CAUSE_IP_SW_HI  = 9;
  localparam int CAUSE_IP_SW_LO  = 8;
  localparam int CAUSE_EXC_HI    = 6;
  localparam int CAUSE_EXC_LO    = 2;

  localparam logic [31:0] STATUS_RESET = 32'h10000000;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_decode_t;

  // Only the five trapping exception types are recorded; eret is handled separately.
  function automatic exc_decode_t decode_exc(input logic [31:0] excepttype);
    exc_decode_t d;
    d.valid = 1'b1;
    d.code  = EXC_CODE_INT;
    case (excepttype)
      EXC_TYPE_INT:     d.code = EXC_CODE_INT;
      EXC_TYPE_SYSCALL: d.code = EXC_CODE_SYSCALL;
      EXC_TYPE_RI:      d.code = EXC_CODE_RI;
      EXC_TYPE_OV:      d.code = EXC_CODE_OV;
      EXC_TYPE_TRAP:    d.code = EXC_CODE_TRAP;
      default:          d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare pair and sticky timer interrupt
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic wr_count;
  logic wr_compare;

  assign wr_count   = we_i && (waddr_i == CP0_REG_COUNT);
  assign wr_compare = we_i && (waddr_i == CP0_REG_COMPARE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o     <= '0;
      compare_o   <= '0;
      timer_int_o <= 1'b0;
    end else begin
      count_o <= wr_count ? wdata_i : count_o + 32'd1;
      // A Compare write acknowledges the interrupt even if it would match this cycle.
      if (wr_compare) begin
        compare_o   <= wdata_i;
        timer_int_o <= 1'b0;
      end else if ((compare_o != '0) && (count_o == compare_o)) begin
        timer_int_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file with exception recording; timer present when CP0_TIMER_EN is defined
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID   = 32'h004c0102,
  parameter logic [31:0] CONFIG = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        timer_int;
  exc_decode_t exc;
  logic        is_eret;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  assign exc       = decode_exc(excepttype_i);
  assign is_eret   = (excepttype_i == EXC_TYPE_ERET);
  assign wr_status = we_i && (waddr_i == CP0_REG_STATUS);
  assign wr_cause  = we_i && (waddr_i == CP0_REG_CAUSE);
  assign wr_epc    = we_i && (waddr_i == CP0_REG_EPC);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_int_o (timer_int)
  );
`else
  assign count_o   = '0;
  assign compare_o = '0;
  assign timer_int = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RESET;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      cause_q[CAUSE_IP_HW_HI:CAUSE_IP_HW_LO] <= {int_i[5] | timer_int, int_i[4:0]};
      // An exception in the same cycle masks software writes to Status, Cause and EPC.
      if (exc.valid) begin
        if (!status_q[STATUS_EXL]) begin
          epc_q             <= in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
          cause_q[CAUSE_BD] <= in_delayslot_i;
        end
        status_q[STATUS_EXL]               <= 1'b1;
        cause_q[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc.code;
      end else begin
        if (is_eret) begin
          status_q[STATUS_EXL] <= 1'b0;
        end else if (wr_status) begin
          status_q <= wdata_i;
        end
        if (wr_cause) begin
          cause_q[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO] <= wdata_i[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO];
          cause_q[CAUSE_WP]                      <= wdata_i[CAUSE_WP];
          cause_q[CAUSE_IV]                      <= wdata_i[CAUSE_IV];
        end
        if (wr_epc) begin
          epc_q <= wdata_i;
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      CP0_REG_COUNT:   data_o = count_o;
      CP0_REG_COMPARE: data_o = compare_o;
      CP0_REG_STATUS:  data_o = status_q;
      CP0_REG_CAUSE:   data_o = cause_q;
      CP0_REG_EPC:     data_o = epc_q;
      CP0_REG_PRID:    data_o = PRID;
      CP0_REG_CONFIG:  data_o = CONFIG;
      default:         data_o = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG;
  assign prid_o      = PRID;
  assign timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - directed and random checks of cp0_regfile against a behavioural model
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [5:0]  irq;
  logic [31:0] excepttype;
  logic [31:0] inst_addr;
  logic        in_delayslot;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_tint;
  logic [31:0] pre_data;

  cp0_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we),
    .waddr_i        (waddr),
    .wdata_i        (wdata),
    .raddr_i        (raddr),
    .int_i          (irq),
    .excepttype_i   (excepttype),
    .inst_addr_i    (inst_addr),
    .in_delayslot_i (in_delayslot),
    .data_o         (data_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .config_o       (config_o),
    .prid_o         (prid_o),
    .timer_int_o    (timer_int_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input logic [31:0] t);
    case (t)
      32'h1:   return 0;
      32'h8:   return 8;
      32'ha:   return 10;
      32'hc:   return 12;
      32'hd:   return 13;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h004c0102;
      5'd16:   return 32'h00008000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_update();
    int          code;
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_tint;
    if (rst) begin
      m_count = 0; m_compare = 0; m_tint = 0;
      m_status = 32'h10000000; m_cause = 0; m_epc = 0;
      return;
    end
    n_count = 0; n_compare = 0; n_tint = 0;
`ifdef CP0_TIMER_EN
    n_count   = (we && waddr == 5'd9) ? wdata : m_count + 1;
    n_compare = m_compare;
    n_tint    = m_tint;
    if (we && waddr == 5'd11) begin
      n_compare = wdata;
      n_tint    = 1'b0;
    end else if (m_compare != 0 && m_count == m_compare) begin
      n_tint = 1'b1;
    end
`endif
    n_status = m_status;
    n_epc    = m_epc;
    n_cause  = (m_cause & ~32'h0000FC00) | (32'({irq[5] | m_tint, irq[4:0]}) << 10);
    code = code_of(excepttype);
    if (code >= 0) begin
      if (m_status[1] == 1'b0) begin
        n_epc   = in_delayslot ? inst_addr - 4 : inst_addr;
        n_cause = (n_cause & ~32'h80000000) | (in_delayslot ? 32'h80000000 : 32'h0);
      end
      n_status = m_status | 32'h2;
      n_cause  = (n_cause & ~32'h0000007C) | (32'(code) << 2);
    end else begin
      if (excepttype == 32'he) n_status = m_status & ~32'h2;
      else if (we && waddr == 5'd12) n_status = wdata;
      if (we && waddr == 5'd13) n_cause = (n_cause & ~32'h00C00300) | (wdata & 32'h00C00300);
      if (we && waddr == 5'd14) n_epc = wdata;
    end
    m_count = n_count; m_compare = n_compare; m_tint = n_tint;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
  endtask

  task automatic check_views();
    chk("count_o",     count_o,   m_count);
    chk("compare_o",   compare_o, m_compare);
    chk("status_o",    status_o,  m_status);
    chk("cause_o",     cause_o,   m_cause);
    chk("epc_o",       epc_o,     m_epc);
    chk("timer_int_o", {31'b0, timer_int_o}, {31'b0, m_tint});
    chk("config_o",    config_o,  32'h00008000);
    chk("prid_o",      prid_o,    32'h004c0102);
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [31:0] et, input logic [31:0] pc,
                      input logic ds, input logic [5:0] ir);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; raddr = ra;
    excepttype = et; inst_addr = pc; in_delayslot = ds; irq = ir;
    #1;
    pre_data = data_o;
    if (!r) chk("data_o", data_o, model_read(ra));
    @(posedge clk);
    model_update();
    #1;
    check_views();
  endtask

  task automatic idle(input logic [4:0] ra);
    step(0, 0, 0, 0, ra, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] addrs [9];
    logic [31:0] etypes [8];
    addrs  = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3, 5'd0};
    etypes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h5, 32'h0};

    // 1. reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_status", status_o, 32'h10000000);
    chk("rst_cause",  cause_o,  32'h0);
    chk("rst_epc",    epc_o,    32'h0);
    chk("rst_count",  count_o,  32'h0);
    chk("rst_tint",   {31'b0, timer_int_o}, 32'h0);
    chk("rst_prid",   prid_o,   32'h004c0102);

    // 2. timer
    step(0, 1, 5'd9,  32'd5,  5'd9, 0, 0, 0, 0);
    step(0, 1, 5'd11, 32'd10, 5'd9, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !m_tint; i++) idle(5'd9);
`ifdef CP0_TIMER_EN
    chk("tint_rise", {31'b0, timer_int_o}, 32'h1);
    chk("tint_count", count_o, 32'd11);
    idle(5'd13);
    idle(5'd13);
    chk("tint_sticky", {31'b0, timer_int_o}, 32'h1);
    chk("tint_ip7", {31'b0, cause_o[15]}, 32'h1);
    step(0, 1, 5'd11, 32'd0, 5'd11, 0, 0, 0, 0);
    chk("tint_clear", {31'b0, timer_int_o}, 32'h0);
`else
    chk("notimer_tint", {31'b0, timer_int_o}, 32'h0);
    chk("notimer_compare", compare_o, 32'h0);
`endif
    idle(5'd13);

    // 3. syscall in delay slot, then nested
    step(0, 0, 0, 0, 5'd14, 32'h8, 32'h100, 1, 0);
    chk("exc_epc", epc_o, 32'hFC);
    chk("exc_bd", {31'b0, cause_o[31]}, 32'h1);
    chk("exc_code", {27'b0, cause_o[6:2]}, 32'd8);
    chk("exc_exl", {31'b0, status_o[1]}, 32'h1);
    step(0, 0, 0, 0, 5'd14, 32'h8, 32'h200, 0, 0);
    chk("exc_nested_epc", epc_o, 32'hFC);

    // 4. eret
    step(0, 0, 0, 0, 5'd12, 32'he, 0, 0, 0);
    chk("eret_exl", {31'b0, status_o[1]}, 32'h0);
    chk("eret_epc", epc_o, 32'hFC);

    // 5. exception beats EPC write; Count write still lands
    step(0, 1, 5'd14, 32'hDEAD, 5'd14, 32'hc, 32'h40, 0, 6'h15);
    chk("exc_vs_epc", epc_o, 32'h40);
    step(0, 1, 5'd9, 32'h1234, 5'd9, 32'h1, 32'h80, 0, 0);
`ifdef CP0_TIMER_EN
    chk("exc_count_wr", count_o, 32'h1234);
`else
    chk("exc_count_wr", count_o, 32'h0);
`endif

    // 6. read during write of Status
    step(0, 1, 5'd12, 32'h10000000, 5'd12, 0, 0, 0, 0);
    chk("rdw_old", pre_data, 32'h10000002);
    idle(5'd12);
    chk("rdw_new", pre_data, 32'h10000000);
    step(0, 1, 5'd9, 32'hFFFFFFFF, 5'd9, 0, 0, 0, 0);
    idle(5'd9);
`ifdef CP0_TIMER_EN
    chk("count_wrap", count_o, 32'h0);
`else
    chk("notimer_count", count_o, 32'h0);
    chk("notimer_tint2", {31'b0, timer_int_o}, 32'h0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] et;
      logic [31:0] wd;
      et = ($urandom_range(0, 3) == 0) ? etypes[$urandom_range(0, 7)] : 32'h0;
      wd = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), addrs[$urandom_range(0, 8)], wd,
           addrs[$urandom_range(0, 8)], et, $urandom, $urandom_range(0, 1), 6'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
